// File: rtl/audio_pwm_dac_pkg.sv
// Shared audio definitions: default sample width, midscale silence code,
// sample type and a helper for sizing the PWM frame counter.
package audio_pwm_dac_pkg;

  localparam int AUDIO_DATA_W = 8;

  typedef logic [AUDIO_DATA_W-1:0] sample_t;

  // Offset-binary silence: only the MSB set.
  localparam sample_t MIDSCALE = {1'b1, {(AUDIO_DATA_W-1){1'b0}}};

  // Width of a counter running 0..frames-1 (at least one bit).
  function automatic int frame_w(input int frames);
    frame_w = (frames > 32'sd1) ? $clog2(frames) : 32'sd1;
  endfunction

endpackage

// File: rtl/audio_pwm_dac_fifo.sv
// Synchronous sample FIFO with push/pop, full/empty flags and occupancy.
// Pushes while full and pops while empty are ignored, so a pop and a push
// on the same edge into an empty FIFO simply stores the new entry.
module sample_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          do_push_s;
  logic          do_pop_s;

  assign full_o  = (count_q == LW'(DEPTH));
  assign empty_o = (count_q == {LW{1'b0}});
  assign level_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Qualify requests against the registered flags and compute pointer/count updates.
  always_comb begin
    do_push_s = push_i && !full_o;
    do_pop_s  = pop_i && !empty_o;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {LW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sample storage; contents are discarded on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: {W{1'b0}}};
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/audio_pwm_dac.sv
// Audio PWM DAC output stage: buffers offset-binary samples in a small FIFO
// and plays each one as PWM_FRAMES frames of 2**DATA_W-clock PWM. An empty
// FIFO at a sample boundary substitutes midscale silence and pulses underrun.
module audio_pwm_dac
  import audio_pwm_dac_pkg::*;
#(
  parameter int DATA_W     = AUDIO_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int PWM_FRAMES = 4,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              pwm_out,
  output logic              underrun,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int                FRAME_W    = frame_w(PWM_FRAMES);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(PWM_FRAMES - 1);
  localparam logic [DATA_W-1:0]  CNT_MAX    = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0]  MID        = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [DATA_W-1:0]  cur_sample_q, cur_sample_d;
  logic               pwm_q, pwm_d;
  logic               underrun_q, underrun_d;
  logic               pop_s;
  logic               boundary_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [DATA_W-1:0]  fifo_head_s;

  sample_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s_valid),
    .data_i  (s_data),
    .pop_i   (pop_s),
    .data_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (fifo_level)
  );

  assign s_ready  = !fifo_full_s;
  assign pwm_out  = pwm_q;
  assign underrun = underrun_q;

  // Counter advance, boundary handling (pop or silence) and PWM compare.
  always_comb begin
    pwm_cnt_d    = pwm_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    cur_sample_d = cur_sample_q;
    pwm_d        = 1'b0;
    underrun_d   = 1'b0;
    pop_s        = 1'b0;
    boundary_s   = (pwm_cnt_q == CNT_MAX) && (frame_cnt_q == FRAME_LAST);
    if (enable) begin
      pwm_cnt_d = pwm_cnt_q + DATA_W'(1);
      if (pwm_cnt_q == CNT_MAX) begin
        if (frame_cnt_q == FRAME_LAST) begin
          frame_cnt_d = {FRAME_W{1'b0}};
        end else begin
          frame_cnt_d = frame_cnt_q + FRAME_W'(1);
        end
      end else begin
        frame_cnt_d = frame_cnt_q;
      end
      if (boundary_s) begin
        if (!fifo_empty_s) begin
          pop_s        = 1'b1;
          cur_sample_d = fifo_head_s;
        end else begin
          cur_sample_d = MID;
          underrun_d   = 1'b1;
        end
      end else begin
        cur_sample_d = cur_sample_q;
      end
      pwm_d = (pwm_cnt_q < cur_sample_q);
    end else begin
      // Disabled: park the counters so the next boundary is a full period away.
      pwm_cnt_d    = {DATA_W{1'b0}};
      frame_cnt_d  = {FRAME_W{1'b0}};
      cur_sample_d = cur_sample_q;
      pwm_d        = 1'b0;
      underrun_d   = 1'b0;
    end
  end

  // Playback state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q    <= {DATA_W{1'b0}};
      frame_cnt_q  <= {FRAME_W{1'b0}};
      cur_sample_q <= MID;
      pwm_q        <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      pwm_cnt_q    <= pwm_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      cur_sample_q <= cur_sample_d;
      pwm_q        <= pwm_d;
      underrun_q   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_audio_pwm_dac.sv
// Directed self-checking bench for audio_pwm_dac (PWM_FRAMES=2, 512-clock sample period).
module tb_audio_pwm_dac;

  localparam int FRAMES = 2;
  localparam int PERIOD = FRAMES * 256;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       pwm_out;
  logic       underrun;
  logic [2:0] fifo_level;

  int checks   = 0;
  int failures = 0;

  int         h;
  logic       ue, un;
  logic [2:0] lp, lq;

  always #5 clk = ~clk;

  audio_pwm_dac #(
    .DATA_W     (8),
    .FIFO_DEPTH (4),
    .PWM_FRAMES (FRAMES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .pwm_out    (pwm_out),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  // Runs one sample period starting with counters at zero; measures high clocks
  // in the first frame, underrun activity, and level just before/after the boundary.
  task automatic run_period(input logic do_push, input logic [7:0] d,
                            output int high, output logic u_early, output logic u_end,
                            output logic [2:0] lvl_pre, output logic [2:0] lvl_post);
    high    = 0;
    u_early = 1'b0;
    lvl_pre = 3'd0;
    for (int i = 1; i <= PERIOD; i++) begin
      if (i == PERIOD) begin
        lvl_pre = fifo_level;
        if (do_push) begin
          s_valid = 1'b1;
          s_data  = d;
        end
      end
      tick();
      s_valid = 1'b0;
      if (i <= 256 && pwm_out === 1'b1) high++;
      if (i < PERIOD && underrun !== 1'b0) u_early = 1'b1;
    end
    u_end    = underrun;
    lvl_post = fifo_level;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    repeat (3) tick();
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", s_ready); end
    checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL reset_pwm got=%b exp=0", pwm_out); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_fifo();
    int exp_h [6] = '{128, 16, 32, 48, 64, 128};
    logic exp_u [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int exp_l [6] = '{3, 2, 1, 0, 0, 0};
    enable  = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = 8'(16 * (i + 1));
      tick();
      checks++; if (fifo_level !== 3'((i + 1 > 4) ? 4 : i + 1)) begin failures++; $display("FAIL full_level[%0d] got=%0d exp=%0d", i, fifo_level, (i + 1 > 4) ? 4 : i + 1); end
      checks++; if (s_ready !== ((i + 1) < 4)) begin failures++; $display("FAIL full_ready[%0d] got=%b exp=%b", i, s_ready, (i + 1) < 4); end
    end
    s_valid = 1'b0;
    enable  = 1'b1;
    for (int p = 0; p < 6; p++) begin
      run_period(1'b0, 8'h00, h, ue, un, lp, lq);
      checks++; if (h !== exp_h[p]) begin failures++; $display("FAIL full_high[%0d] got=%0d exp=%0d", p, h, exp_h[p]); end
      checks++; if (un !== exp_u[p] || ue !== 1'b0) begin failures++; $display("FAIL full_underrun[%0d] got=%b/%b exp=%b/0", p, un, ue, exp_u[p]); end
      checks++; if (lq !== 3'(exp_l[p])) begin failures++; $display("FAIL full_lvl[%0d] got=%0d exp=%0d", p, lq, exp_l[p]); end
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_duty();
    int exp_h [4] = '{128, 0, 255, 64};
    logic exp_u [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    push(8'h00); push(8'hFF); push(8'h40);
    enable = 1'b1;
    for (int p = 0; p < 4; p++) begin
      run_period(1'b0, 8'h00, h, ue, un, lp, lq);
      checks++; if (h !== exp_h[p]) begin failures++; $display("FAIL duty_high[%0d] got=%0d exp=%0d", p, h, exp_h[p]); end
      checks++; if (un !== exp_u[p] || ue !== 1'b0) begin failures++; $display("FAIL duty_underrun[%0d] got=%b/%b exp=%b/0", p, un, ue, exp_u[p]); end
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_underrun();
    int exp_h [3] = '{128, 32, 128};
    logic exp_u [3] = '{1'b0, 1'b1, 1'b1};
    push(8'h20);
    enable = 1'b1;
    for (int p = 0; p < 3; p++) begin
      run_period(1'b0, 8'h00, h, ue, un, lp, lq);
      checks++; if (h !== exp_h[p]) begin failures++; $display("FAIL undr_high[%0d] got=%0d exp=%0d", p, h, exp_h[p]); end
      checks++; if (un !== exp_u[p] || ue !== 1'b0) begin failures++; $display("FAIL undr_pulse[%0d] got=%b/%b exp=%b/0", p, un, ue, exp_u[p]); end
    end
    tick();
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL undr_width got=%b exp=0", underrun); end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_simul_push_pop();
    logic do_p [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] pd [6] = '{8'h33, 8'h00, 8'h00, 8'h44, 8'h00, 8'h00};
    int exp_h [6] = '{128, 17, 34, 51, 128, 68};
    logic exp_u [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int exp_l [6] = '{2, 1, 0, 1, 0, 0};
    push(8'h11); push(8'h22);
    enable = 1'b1;
    for (int p = 0; p < 6; p++) begin
      run_period(do_p[p], pd[p], h, ue, un, lp, lq);
      checks++; if (h !== exp_h[p]) begin failures++; $display("FAIL simul_high[%0d] got=%0d exp=%0d", p, h, exp_h[p]); end
      checks++; if (un !== exp_u[p] || ue !== 1'b0) begin failures++; $display("FAIL simul_underrun[%0d] got=%b/%b exp=%b/0", p, un, ue, exp_u[p]); end
      checks++; if (lq !== 3'(exp_l[p])) begin failures++; $display("FAIL simul_lvl[%0d] got=%0d exp=%0d", p, lq, exp_l[p]); end
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_enable_toggle();
    logic bad;
    push(8'h30); push(8'h50); push(8'h60);
    enable = 1'b1;
    run_period(1'b0, 8'h00, h, ue, un, lp, lq);
    checks++; if (h !== 128 || lq !== 3'd2) begin failures++; $display("FAIL tog_first got=%0d/%0d exp=128/2", h, lq); end
    repeat (20) tick();
    checks++; if (pwm_out !== 1'b1) begin failures++; $display("FAIL tog_pre_high got=%b exp=1", pwm_out); end
    enable = 1'b0;
    tick();
    checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL tog_off_pwm got=%b exp=0", pwm_out); end
    bad = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (pwm_out !== 1'b0 || underrun !== 1'b0 || fifo_level !== 3'd2) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL tog_idle got=%b exp=0", bad); end
    enable = 1'b1;
    run_period(1'b0, 8'h00, h, ue, un, lp, lq);
    checks++; if (h !== 48) begin failures++; $display("FAIL tog_held_high got=%0d exp=48", h); end
    checks++; if (lp !== 3'd2 || lq !== 3'd1) begin failures++; $display("FAIL tog_pop_time got=%0d->%0d exp=2->1", lp, lq); end
    checks++; if (un !== 1'b0 || ue !== 1'b0) begin failures++; $display("FAIL tog_underrun got=%b/%b exp=0/0", un, ue); end
    run_period(1'b0, 8'h00, h, ue, un, lp, lq);
    checks++; if (h !== 80 || un !== 1'b0) begin failures++; $display("FAIL tog_second got=%0d/%b exp=80/0", h, un); end
    run_period(1'b0, 8'h00, h, ue, un, lp, lq);
    checks++; if (h !== 96 || un !== 1'b1) begin failures++; $display("FAIL tog_third got=%0d/%b exp=96/1", h, un); end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    push(8'hA0); push(8'hB0); push(8'hC0); push(8'hD0);
    enable = 1'b1;
    run_period(1'b0, 8'h00, h, ue, un, lp, lq);
    checks++; if (h !== 128 || lq !== 3'd3) begin failures++; $display("FAIL rmid_setup got=%0d/%0d exp=128/3", h, lq); end
    repeat (50) tick();
    checks++; if (pwm_out !== 1'b1) begin failures++; $display("FAIL rmid_pre_high got=%b exp=1", pwm_out); end
    rst = 1'b1;
    #1;
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL rmid_level got=%0d exp=0", fifo_level); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", s_ready); end
    checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL rmid_pwm got=%b exp=0", pwm_out); end
    tick();
    rst = 1'b0;
    run_period(1'b0, 8'h00, h, ue, un, lp, lq);
    checks++; if (h !== 128) begin failures++; $display("FAIL rmid_midscale got=%0d exp=128", h); end
    checks++; if (un !== 1'b1 || ue !== 1'b0 || lq !== 3'd0) begin failures++; $display("FAIL rmid_underrun got=%b/%b/%0d exp=1/0/0", un, ue, lq); end
    enable = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_full_fifo();
    test_duty();
    test_underrun();
    test_simul_push_pop();
    test_enable_toggle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
